// File: rtl/udp_oe_tx_sched.sv
// Packet-atomic TX scheduler sharing the MAC stream between the UDP and ARP reply builders.
// Define UDP_OE_TX_SCHED_WATCHDOG_EN to enable the ARP first-beat watchdog.
module udp_oe_tx_sched #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ARP_PEND_MAX = 4,
  parameter int unsigned ARP_BURST    = 2,
  parameter int unsigned ARP_TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arp_trigger,
  output logic                arp_start,
  input  logic                arp_tvalid,
  input  logic                arp_tlast,
  input  logic [DATA_W-1:0]   arp_tdata,
  input  logic [DATA_W/8-1:0] arp_tkeep,
  output logic                arp_tready,
  input  logic                udp_tvalid,
  input  logic                udp_tlast,
  input  logic [DATA_W-1:0]   udp_tdata,
  input  logic [DATA_W/8-1:0] udp_tkeep,
  output logic                udp_tready,
  output logic                tx_tvalid,
  output logic                tx_tlast,
  output logic [DATA_W-1:0]   tx_tdata,
  output logic [DATA_W/8-1:0] tx_tkeep,
  input  logic                tx_tready,
  output logic [3:0]          arp_pending,
  output logic [15:0]         arp_drop_cnt,
  output logic [15:0]         arp_timeout_cnt,
  output logic [1:0]          sm_state
);

  localparam int unsigned BurstW = (ARP_BURST > 0) ? $clog2(ARP_BURST + 1) : 1;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StArpStart = 2'd1,
    StArpXfer  = 2'd2,
    StUdpXfer  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        pend_q, pend_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [15:0]       drop_q, drop_d;
  logic              tx_fire;
  logic              wd_timeout;

  assign tx_fire = tx_tvalid & tx_tready;

`ifdef UDP_OE_TX_SCHED_WATCHDOG_EN
  localparam int unsigned WdW = (ARP_TIMEOUT > 1) ? $clog2(ARP_TIMEOUT + 1) : 1;

  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           wd_armed_q, wd_armed_d;
  logic [15:0]    tmo_q, tmo_d;

  // Armed from ARP_START until the first accepted ARP beat.
  always_comb begin
    wd_cnt_d   = wd_cnt_q;
    wd_armed_d = wd_armed_q;
    tmo_d      = tmo_q;
    wd_timeout = 1'b0;
    if (state_q == StArpStart) begin
      wd_cnt_d   = '0;
      wd_armed_d = 1'b1;
    end else if (state_q == StArpXfer && wd_armed_q) begin
      if (tx_fire) begin
        wd_armed_d = 1'b0;
      end else if (wd_cnt_q == WdW'(ARP_TIMEOUT - 1)) begin
        wd_timeout = 1'b1;
        wd_armed_d = 1'b0;
        tmo_d      = tmo_q + 16'd1;
      end else begin
        wd_cnt_d = wd_cnt_q + WdW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_q   <= '0;
      wd_armed_q <= 1'b0;
      tmo_q      <= '0;
    end else begin
      wd_cnt_q   <= wd_cnt_d;
      wd_armed_q <= wd_armed_d;
      tmo_q      <= tmo_d;
    end
  end

  assign arp_timeout_cnt = tmo_q;
`else
  logic unused_timeout;
  assign unused_timeout  = ^ARP_TIMEOUT;
  assign wd_timeout      = 1'b0;
  assign arp_timeout_cnt = 16'h0000;
`endif

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q != 4'd0 && (burst_q < BurstW'(ARP_BURST) || !udp_tvalid)) begin
          state_d = StArpStart;
        end else if (udp_tvalid) begin
          state_d = StUdpXfer;
          burst_d = '0;
        end
      end
      StArpStart: begin
        state_d = StArpXfer;
        if (burst_q < BurstW'(ARP_BURST)) burst_d = burst_q + BurstW'(1);
      end
      StArpXfer: begin
        if ((tx_fire && tx_tlast) || wd_timeout) state_d = StIdle;
      end
      StUdpXfer: begin
        if (tx_fire && tx_tlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full queue drops the trigger unless a request is consumed the same cycle.
  always_comb begin
    pend_d = pend_q;
    drop_d = drop_q;
    if (arp_trigger && state_q != StArpStart) begin
      if (pend_q == 4'(ARP_PEND_MAX)) drop_d = drop_q + 16'd1;
      else                            pend_d = pend_q + 4'd1;
    end else if (!arp_trigger && state_q == StArpStart) begin
      pend_d = pend_q - 4'd1;
    end
  end

  always_comb begin
    tx_tvalid  = 1'b0;
    tx_tlast   = 1'b0;
    tx_tdata   = '0;
    tx_tkeep   = '0;
    arp_tready = 1'b0;
    udp_tready = 1'b0;
    unique case (state_q)
      StArpXfer: begin
        tx_tvalid  = arp_tvalid;
        tx_tlast   = arp_tlast;
        tx_tdata   = arp_tdata;
        tx_tkeep   = arp_tkeep;
        arp_tready = tx_tready;
      end
      StUdpXfer: begin
        tx_tvalid  = udp_tvalid;
        tx_tlast   = udp_tlast;
        tx_tdata   = udp_tdata;
        tx_tkeep   = udp_tkeep;
        udp_tready = tx_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      burst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      burst_q <= burst_d;
      drop_q  <= drop_d;
    end
  end

  assign arp_start    = (state_q == StArpStart);
  assign arp_pending  = pend_q;
  assign arp_drop_cnt = drop_q;
  assign sm_state     = state_q;

endmodule

// File: tb/tb_udp_oe_tx_sched.sv
// Scoreboard bench for udp_oe_tx_sched: builder models feed the DUT, a monitor checks TX beats
// against expected packets queued when stimulus is issued.
module tb_udp_oe_tx_sched;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        arp_trigger;
  logic        arp_start;
  logic        arp_tvalid, arp_tlast, arp_tready;
  logic [63:0] arp_tdata;
  logic [7:0]  arp_tkeep;
  logic        udp_tvalid, udp_tlast, udp_tready;
  logic [63:0] udp_tdata;
  logic [7:0]  udp_tkeep;
  logic        tx_tvalid, tx_tlast, tx_tready;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic [3:0]  arp_pending;
  logic [15:0] arp_drop_cnt, arp_timeout_cnt;
  logic [1:0]  sm_state;

  beat_t exp_q[$];
  beat_t udp_q[$];
  beat_t arp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_arp = 0;
  int    arp_pkt = 0;
  logic  tx_stall = 1'b0;
  logic  tx_toggle = 1'b0;
  logic  arp_silent = 1'b0;

  udp_oe_tx_sched #(
    .DATA_W      (64),
    .ARP_PEND_MAX(4),
    .ARP_BURST   (2),
    .ARP_TIMEOUT (255)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arp_trigger    (arp_trigger),
    .arp_start      (arp_start),
    .arp_tvalid     (arp_tvalid),
    .arp_tlast      (arp_tlast),
    .arp_tdata      (arp_tdata),
    .arp_tkeep      (arp_tkeep),
    .arp_tready     (arp_tready),
    .udp_tvalid     (udp_tvalid),
    .udp_tlast      (udp_tlast),
    .udp_tdata      (udp_tdata),
    .udp_tkeep      (udp_tkeep),
    .udp_tready     (udp_tready),
    .tx_tvalid      (tx_tvalid),
    .tx_tlast       (tx_tlast),
    .tx_tdata       (tx_tdata),
    .tx_tkeep       (tx_tkeep),
    .tx_tready      (tx_tready),
    .arp_pending    (arp_pending),
    .arp_drop_cnt   (arp_drop_cnt),
    .arp_timeout_cnt(arp_timeout_cnt),
    .sm_state       (sm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic beat_t arp_beat(input int p, input int b);
    beat_t r;
    r.d = {16'hA000, 16'(p), 16'(b), 16'h0A0A};
    r.k = (b == 5) ? 8'h0F : 8'hFF;
    r.l = (b == 5);
    return r;
  endfunction

  function automatic beat_t udp_beat(input int p, input int b, input int n);
    beat_t r;
    r.d = {16'hD000, 16'(p), 16'(b), 16'h5555};
    r.k = (b == n - 1) ? 8'h3F : 8'hFF;
    r.l = (b == n - 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic push_arp_exp();
    for (int b = 0; b < 6; b++) exp_q.push_back(arp_beat(exp_arp, b));
    exp_arp++;
  endtask

  task automatic send_udp(input int p, input int n);
    for (int b = 0; b < n; b++) begin
      udp_q.push_back(udp_beat(p, b, n));
      exp_q.push_back(udp_beat(p, b, n));
    end
  endtask

  task automatic pulse_trig(input int n);
    arp_trigger = 1'b1;
    repeat (n) tick();
    arp_trigger = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sm_state == 2'd0 && exp_q.size() == 0 && arp_pending == 4'd0) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 64'(done), 64'd1);
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sm_state == s) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, 64'(done), 64'd1);
  endtask

  // MAC ready model.
  initial begin
    tx_tready = 1'b0;
    forever begin
      tick();
      if (tx_stall)       tx_tready = 1'b0;
      else if (tx_toggle) tx_tready = ~tx_tready;
      else                tx_tready = 1'b1;
    end
  end

  // UDP builder model.
  initial begin
    logic fire, rs;
    udp_tvalid = 1'b0; udp_tlast = 1'b0; udp_tdata = '0; udp_tkeep = '0;
    forever begin
      @(negedge clk);
      fire = udp_tvalid & udp_tready;
      rs   = ~rst_n;
      tick();
      if (rs) udp_q.delete();
      else if (fire && udp_q.size() > 0) void'(udp_q.pop_front());
      if (udp_q.size() > 0) begin
        udp_tvalid = 1'b1;
        {udp_tdata, udp_tkeep, udp_tlast} = udp_q[0];
      end else begin
        udp_tvalid = 1'b0; udp_tlast = 1'b0; udp_tdata = '0; udp_tkeep = '0;
      end
    end
  end

  // ARP builder model: one 6-beat reply per arp_start unless silenced.
  initial begin
    logic fire, st, rs;
    arp_tvalid = 1'b0; arp_tlast = 1'b0; arp_tdata = '0; arp_tkeep = '0;
    forever begin
      @(negedge clk);
      fire = arp_tvalid & arp_tready;
      st   = arp_start;
      rs   = ~rst_n;
      tick();
      if (rs) begin
        arp_q.delete();
        arp_pkt = 0;
      end else begin
        if (fire && arp_q.size() > 0) void'(arp_q.pop_front());
        if (st && !arp_silent) begin
          for (int b = 0; b < 6; b++) arp_q.push_back(arp_beat(arp_pkt, b));
          arp_pkt++;
        end
      end
      if (arp_q.size() > 0) begin
        arp_tvalid = 1'b1;
        {arp_tdata, arp_tkeep, arp_tlast} = arp_q[0];
      end else begin
        arp_tvalid = 1'b0; arp_tlast = 1'b0; arp_tdata = '0; arp_tkeep = '0;
      end
    end
  end

  // TX monitor.
  initial begin
    beat_t got, want;
    forever begin
      @(negedge clk);
      if (tx_tvalid && tx_tready) begin
        got = {tx_tdata, tx_tkeep, tx_tlast};
        chk("one_grant", 64'(arp_tready & udp_tready), 64'd0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected actual=%h expected=none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL tx_beat actual=%h expected=%h", got, want);
          end
        end
      end
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    logic found;
    int   cnt;
    rst_n = 1'b0;
    arp_trigger = 1'b0;
    repeat (3) tick();
    chk("rst_state", 64'(sm_state), 64'd0);
    chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(tx_tlast), 64'd0);
    chk("rst_tdata", tx_tdata, 64'd0);
    chk("rst_tkeep", 64'(tx_tkeep), 64'd0);
    chk("rst_start", 64'(arp_start), 64'd0);
    chk("rst_treadys", 64'({arp_tready, udp_tready}), 64'd0);
    chk("rst_pend", 64'(arp_pending), 64'd0);
    chk("rst_drop", 64'(arp_drop_cnt), 64'd0);
    chk("rst_tmo", 64'(arp_timeout_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single ARP: start two cycles after the trigger.
    push_arp_exp();
    pulse_trig(1);
    chk("single_pend", 64'(arp_pending), 64'd1);
    chk("single_start_early", 64'(arp_start), 64'd0);
    tick();
    chk("single_start", 64'(arp_start), 64'd1);
    chk("single_state", 64'(sm_state), 64'd1);
    tick();
    chk("single_start_once", 64'(arp_start), 64'd0);
    chk("single_pend_dec", 64'(arp_pending), 64'd0);
    wait_idle("single_drain", 100);

    // UDP under toggling backpressure.
    tx_toggle = 1'b1;
    send_udp(1, 8);
    wait_idle("udp_bp_drain", 100);
    tx_toggle = 1'b0;

    // Fairness: expected order A, ARP, ARP, B, ARP, ARP.
    tx_stall = 1'b1;
    send_udp(2, 2);
    push_arp_exp();
    push_arp_exp();
    send_udp(3, 2);
    push_arp_exp();
    push_arp_exp();
    wait_state("fair_udp_grant", 2'd3, 20);
    pulse_trig(4);
    chk("fair_pend", 64'(arp_pending), 64'd4);
    chk("fair_drop", 64'(arp_drop_cnt), 64'd0);
    tx_stall = 1'b0;
    wait_idle("fair_drain", 400);

    // No preemption, then a trigger coinciding with ARP_START.
    send_udp(4, 5);
    push_arp_exp();
    wait_state("np_udp_grant", 2'd3, 20);
    pulse_trig(1);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (arp_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("np_start_seen", 64'(found), 64'd1);
    chk("np_udp_done", 64'(exp_q.size()), 64'd6);
    push_arp_exp();
    pulse_trig(1);
    chk("np_pend_hold", 64'(arp_pending), 64'd1);
    wait_idle("np_drain", 200);

    // Overflow while UDP is stalled, then reset mid-packet.
    tx_stall = 1'b1;
    send_udp(5, 8);
    wait_state("ov_udp_grant", 2'd3, 20);
    pulse_trig(6);
    chk("ov_pend", 64'(arp_pending), 64'd4);
    chk("ov_drop", 64'(arp_drop_cnt), 64'd2);
    tx_stall = 1'b0;
    repeat (3) tick();
    chk("mid_pkt_state", 64'(sm_state), 64'd3);
    rst_n = 1'b0;
    tick();
    chk("mrst_state", 64'(sm_state), 64'd0);
    chk("mrst_tvalid", 64'(tx_tvalid), 64'd0);
    chk("mrst_tlast", 64'(tx_tlast), 64'd0);
    chk("mrst_tdata", tx_tdata, 64'd0);
    chk("mrst_tkeep", 64'(tx_tkeep), 64'd0);
    chk("mrst_treadys", 64'({arp_tready, udp_tready}), 64'd0);
    chk("mrst_start", 64'(arp_start), 64'd0);
    chk("mrst_pend", 64'(arp_pending), 64'd0);
    chk("mrst_drop", 64'(arp_drop_cnt), 64'd0);
    exp_q.delete();
    exp_arp = 0;
    rst_n = 1'b1;
    tick();

`ifdef UDP_OE_TX_SCHED_WATCHDOG_EN
    arp_silent = 1'b1;
    pulse_trig(1);
    cnt = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (sm_state == 2'd2) cnt++;
      else if (cnt > 0 && sm_state == 2'd0) break;
    end
    chk("wd_cycles", 64'(cnt), 64'd255);
    chk("wd_state", 64'(sm_state), 64'd0);
    chk("wd_tmo_cnt", 64'(arp_timeout_cnt), 64'd1);
    chk("wd_pend", 64'(arp_pending), 64'd0);
    arp_silent = 1'b0;
    push_arp_exp();
    pulse_trig(1);
    wait_idle("wd_recover", 100);
`else
    cnt = 0;
    chk("tmo_tied", 64'(arp_timeout_cnt) + 64'(cnt), 64'd0);
`endif

    repeat (3) tick();
    chk("end_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
